// File: rtl/instruction_memory_loader.sv
// Host byte-stream loader for the core's instruction memory: assembles big-endian words, writes them
// sequentially, and holds the core in reset until the image is in. Optional checksum: INSTRUCTION_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module instruction_memory_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  memory_write_enable,
  output logic [ADDR_WIDTH-1:0] memory_write_address,
  output logic [31:0]           memory_write_value,
  output logic                  processor_reset,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK  = 3'd4;
`endif
  localparam logic [2:0] S_FLUSH  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_AFTER_DATA = S_CHECK;
`else
  localparam logic [2:0] S_AFTER_DATA = S_FLUSH;
`endif

  // 17 bits so that DEPTH = 65536 (ADDR_WIDTH = 16) is still representable.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  logic [2:0]          r_state;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_len;
  logic [ADDR_WIDTH:0] r_word_idx;
  logic [1:0]          r_lane;
  logic [23:0]         r_shift;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
`endif

  logic [2:0]  w_next;
  logic        w_xfer;
  logic        w_accepting;
  logic        w_last_word;
  logic [15:0] w_len_in;
  logic [31:0] w_word;

  assign w_xfer      = byte_valid && byte_ready;
  assign w_len_in    = {r_len_hi, byte_data};
  assign w_word      = {r_shift, byte_data};
  assign w_last_word = (17'(r_word_idx) + 17'd1) == {1'b0, r_len};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_xfer) begin
          if ({1'b0, w_len_in} > DEPTH) w_next = S_ERROR;
          else if (w_len_in == 16'd0)   w_next = S_AFTER_DATA;
          else                          w_next = S_DATA;
        end
      end
      S_DATA: if (w_xfer && r_lane == 2'd3 && w_last_word) w_next = S_AFTER_DATA;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_CHECK: if (w_xfer) w_next = (byte_data == r_sum) ? S_FLUSH : S_ERROR;
`endif
      S_FLUSH: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accepting = 1'b0;
    case (w_next)
      S_LEN_HI, S_LEN_LO, S_DATA: w_accepting = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_CHECK: w_accepting = 1'b1;
`endif
      default: w_accepting = 1'b0;
    endcase
  end

  // Status outputs are registered from the next state so they line up with r_state.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state              <= S_IDLE;
      r_len_hi             <= '0;
      r_len                <= '0;
      r_word_idx           <= '0;
      r_lane               <= '0;
      r_shift              <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      r_sum                <= '0;
`endif
      byte_ready           <= 1'b0;
      memory_write_enable  <= 1'b0;
      memory_write_address <= '0;
      memory_write_value   <= '0;
      processor_reset      <= 1'b1;
      load_done            <= 1'b0;
      load_error           <= 1'b0;
    end else begin
      r_state             <= w_next;
      byte_ready          <= w_accepting;
      processor_reset     <= (w_next != S_DONE);
      load_done           <= (w_next == S_DONE);
      load_error          <= (w_next == S_ERROR);
      memory_write_enable <= 1'b0;

      if (r_state == S_LEN_HI && w_xfer) r_len_hi <= byte_data;

      if (r_state == S_LEN_LO && w_xfer) begin
        r_len      <= w_len_in;
        r_word_idx <= '0;
        r_lane     <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        r_sum      <= '0;
`endif
      end

      if (r_state == S_DATA && w_xfer) begin
        r_shift <= w_word[23:0];
        r_lane  <= r_lane + 2'd1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        r_sum   <= r_sum + byte_data;
`endif
        if (r_lane == 2'd3) begin
          memory_write_enable  <= 1'b1;
          memory_write_address <= r_word_idx[ADDR_WIDTH-1:0];
          memory_write_value   <= w_word;
          r_word_idx           <= r_word_idx + 1'b1;
        end
      end
    end
  end

endmodule
